// File: rtl/scan_decoder_pkg.sv
// Shared encodings and sizing helpers for the scan decoder.
package scan_decoder_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Number of one-hot outputs for an N-bit select.
    function automatic int unsigned num_out(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // Bits needed to hold DWELL-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned dwell);
        return (dwell > 32'd1) ? $clog2(dwell) : 32'd1;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control and decoded-output bundle between a controller and the scan decoder.
interface scan_decoder_if #(
    parameter int unsigned N = 4
);
    import scan_decoder_pkg::*;

    localparam int unsigned NUM_OUT = num_out(N);

    logic [N-1:0]         w;
    logic                 En;
    logic                 Load;
    logic                 Mode;
    logic                 Dir;
    logic [0:NUM_OUT-1]   y;
    logic [N-1:0]         Idx;
    logic                 Wrap;

    modport master (
        output w, En, Load, Mode, Dir,
        input  y, Idx, Wrap
    );

    modport slave (
        input  w, En, Load, Mode, Dir,
        output y, Idx, Wrap
    );

endinterface

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational N-to-2**N one-hot decoder with an output enable.
module onehot_dec
    import scan_decoder_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          sel_i,
    input  logic                  en_i,
    output logic [0:num_out(N)-1] y_o
);

    // Drive exactly the selected line when enabled, nothing otherwise.
    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Loadable one-hot decoder with an optional dwell-timed auto-scan of the index.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DWELL = 1
) (
    input  logic          Clock,
    input  logic          Reset,
    scan_decoder_if.slave bus
);

    localparam int unsigned NUM_OUT  = num_out(N);
    localparam int unsigned DW       = cnt_width(DWELL);
    localparam logic [N-1:0] IDX_MAX = N'(NUM_OUT - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DWELL - 1);
    // A 1-bit index wraps on every move, whichever way it goes.
    localparam bit   WRAP_ALWAYS = (N == 1);

    logic [N-1:0]       idx_q, idx_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic               wrap_q, wrap_d;
    logic               en_q;
    logic               mode_q;
    logic               dir_q;
    logic               seen_q;
    logic               chg_c;
    logic [0:NUM_OUT-1] y_c;

    // Next index, dwell count and wrap flag; Load beats a mode/dir change, which beats a scan step.
    always_comb begin
        idx_d  = idx_q;
        dcnt_d = dcnt_q;
        wrap_d = 1'b0;
        // mode_q/dir_q are only meaningful once one edge has been seen since reset.
        chg_c  = seen_q && ((bus.Mode != mode_q) || (bus.Dir != dir_q));

        if (bus.Load) begin
            idx_d  = bus.w;
            dcnt_d = '0;
        end else if (bus.Mode == MODE_DIRECT) begin
            dcnt_d = '0;
        end else if (chg_c) begin
            dcnt_d = '0;
        end else if (bus.En) begin
            if (dcnt_q == DCNT_LAST) begin
                dcnt_d = '0;
                if (bus.Dir == DIR_UP) begin
                    idx_d  = idx_q + N'(1);
                    wrap_d = WRAP_ALWAYS || (idx_q == IDX_MAX);
                end else begin
                    idx_d  = idx_q - N'(1);
                    wrap_d = WRAP_ALWAYS || (idx_q == '0);
                end
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    // State register; reset clears everything without waiting for a clock.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idx_q  <= '0;
            dcnt_q <= '0;
            wrap_q <= 1'b0;
            en_q   <= 1'b0;
            mode_q <= 1'b0;
            dir_q  <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            dcnt_q <= dcnt_d;
            wrap_q <= wrap_d;
            en_q   <= bus.En;
            mode_q <= bus.Mode;
            dir_q  <= bus.Dir;
            seen_q <= 1'b1;
        end
    end

    onehot_dec #(
        .N (N)
    ) u_dec (
        .sel_i (idx_q),
        .en_i  (en_q),
        .y_o   (y_c)
    );

    assign bus.y    = y_c;
    assign bus.Idx  = idx_q;
    assign bus.Wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder (N=4, DWELL=3) with a cycle-level reference model.
module tb_scan_decoder;

    localparam int N     = 4;
    localparam int DWELL = 3;
    localparam int NUM   = 16;

    typedef struct {
        int idx;
        bit en;
        bit wrap;
    } exp_t;

    logic Clock;
    logic Reset;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    // Reference model state, owned by the stimulus process.
    int m_idx;
    int m_dwelt;
    bit m_en;
    bit m_wrap;
    bit m_pmode;
    bit m_pdir;
    bit m_seen;

    scan_decoder_if #(.N(N)) bus ();

    scan_decoder #(
        .N     (N),
        .DWELL (DWELL)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Apply one cycle of inputs at the falling edge and predict the state after the next rising edge.
    task automatic cyc(input int w, input bit en, input bit ld, input bit md, input bit dr, input bit rs);
        exp_t e;
        bit   rising;
        @(negedge Clock);
        rising   = rs && !Reset;
        bus.w    = 4'(w);
        bus.En   = en;
        bus.Load = ld;
        bus.Mode = md;
        bus.Dir  = dr;
        Reset    = rs;
        if (rising) begin
            #1;
            checks++;
            if (bus.y !== '0 || bus.Idx !== 4'd0 || bus.Wrap !== 1'b0) begin
                errors++;
                $display("FAIL async_reset: y=%b Idx=%0d Wrap=%b required y=0 Idx=0 Wrap=0",
                         bus.y, bus.Idx, bus.Wrap);
            end
        end
        if (rs) begin
            m_idx = 0; m_dwelt = 0; m_en = 0; m_wrap = 0; m_seen = 0;
        end else begin
            m_wrap = 0;
            if (ld) begin
                m_idx   = w;
                m_dwelt = 0;
            end else if (!md) begin
                m_dwelt = 0;
            end else if (m_seen && (md != m_pmode || dr != m_pdir)) begin
                m_dwelt = 0;
            end else if (en) begin
                m_dwelt++;
                if (m_dwelt == DWELL) begin
                    m_dwelt = 0;
                    if (!dr) begin
                        m_wrap = (m_idx == NUM - 1);
                        m_idx  = (m_idx + 1) % NUM;
                    end else begin
                        m_wrap = (m_idx == 0);
                        m_idx  = (m_idx + NUM - 1) % NUM;
                    end
                end
            end
            m_en    = en;
            m_pmode = md;
            m_pdir  = dr;
            m_seen  = 1;
        end
        e.idx  = m_idx;
        e.en   = m_en;
        e.wrap = m_wrap;
        exp_q.push_back(e);
    endtask

    // Monitor: after each rising edge compare the visible outputs with the oldest prediction.
    exp_t        mon_e;
    logic [0:15] mon_y;
    always @(posedge Clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int k = 0; k < NUM; k++) mon_y[k] = mon_e.en && (k == mon_e.idx);
            checks++;
            if (bus.y !== mon_y) begin
                errors++;
                $display("FAIL y: got %b required %b at %0t", bus.y, mon_y, $time);
            end
            checks++;
            if (bus.Idx !== 4'(mon_e.idx)) begin
                errors++;
                $display("FAIL idx: got %0d required %0d at %0t", bus.Idx, mon_e.idx, $time);
            end
            checks++;
            if (bus.Wrap !== mon_e.wrap) begin
                errors++;
                $display("FAIL wrap: got %b required %b at %0t", bus.Wrap, mon_e.wrap, $time);
            end
        end
    end

    initial begin
        errors   = 0;
        checks   = 0;
        Reset    = 1'b1;
        bus.w    = '0;
        bus.En   = 1'b0;
        bus.Load = 1'b0;
        bus.Mode = 1'b0;
        bus.Dir  = 1'b0;
        m_idx = 0; m_dwelt = 0; m_en = 0; m_wrap = 0; m_pmode = 0; m_pdir = 0; m_seen = 0;

        #1;
        checks++;
        if (bus.y !== '0 || bus.Idx !== 4'd0 || bus.Wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: y=%b Idx=%0d Wrap=%b required all zero", bus.y, bus.Idx, bus.Wrap);
        end
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Direct decode of 9, held steady.
        cyc(9, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);

        // Upward scan across the 15 -> 0 wrap.
        cyc(14, 1, 1, 1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 1, 0, 0);

        // Downward scan across the 0 -> 15 wrap.
        cyc(1, 1, 1, 1, 1, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, 1, 1, 0);

        // Enable dropped mid-dwell, then restored.
        cyc(5, 1, 1, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0, 0);

        // Load colliding with a due 7 -> 8 step.
        cyc(6, 1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0, 0);
        cyc(3, 1, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0, 0);

        // Asynchronous reset mid-dwell at 12, then restart of the scan.
        cyc(12, 1, 1, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 1, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 1, 0, 0);

        // Direction flip mid-dwell clears the count.
        cyc(0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 1, 0);

        // Randomized traffic.
        begin
            bit md, dr;
            md = 1; dr = 0;
            for (int i = 0; i < 400; i++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if ($urandom_range(0, 99) < 4) md = ~md;
                if ($urandom_range(0, 99) < 6) dr = ~dr;
                if (r < 2) begin
                    cyc(int'($urandom_range(0, 15)), 1, 0, md, dr, 1);
                end else begin
                    cyc(int'($urandom_range(0, 15)), ($urandom_range(0, 99) < 85),
                        ($urandom_range(0, 99) < 8), md, dr, 0);
                end
            end
        end

        cyc(0, 0, 0, 0, 0, 0);
        @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter N, default 4, select width; the block drives 2**N one-hot outputs; legal range 1..6.
REQ-002 Parameter DWELL, default 1, scan-mode cycles per output position; legal range 1..255.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 w  input  N  select value, captured when Load=1.
REQ-006 En  input  1  enable; 0 forces all outputs low and freezes the scan.
REQ-007 Load  input  1  capture w into the index register.
REQ-008 Mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-009 Dir  input  1  scan direction; 0 = increment, 1 = decrement.
REQ-010 y  output  2**N  one-hot decoded output, indexed [0:2**N-1]; y[k] high when index = k.
REQ-011 Idx  output  N  current index register value.
REQ-012 Wrap  output  1  single-cycle pulse on a scan wrap-around.

Function
REQ-013 State SHALL be index register idx[N-1:0], registered enable en_q, dwell counter dcnt, and registered Wrap.
REQ-014 y SHALL equal onehot(idx) when en_q=1, else all zeros; y is a function of registered state only, with no combinational path from inputs.
REQ-015 Idx SHALL equal idx at all times, independent of En.
REQ-016 en_q SHALL load En on every edge; y therefore follows En with one cycle of latency.
REQ-017 Load=1 at an edge SHALL set idx to w and dcnt to 0 in both modes; y shows the decoded w from the following cycle, a one-cycle latency.
REQ-018 Load SHALL have priority over a scan step in the same cycle; no Wrap pulse results from a Load.
REQ-019 Mode=0: idx SHALL change only on Load; dcnt SHALL be held at 0.
REQ-020 Mode=1, En=1, Load=0: dcnt SHALL increment each cycle; when dcnt = DWELL-1, dcnt returns to 0 and idx steps by +1 (Dir=0) or -1 (Dir=1), modulo 2**N.
REQ-021 Wrap SHALL pulse high for exactly one cycle, in the cycle after a step from 2**N-1 to 0 (Dir=0) or from 0 to 2**N-1 (Dir=1); otherwise it is 0.
REQ-022 Mode=1, En=0: idx and dcnt SHALL hold their values; Wrap SHALL be 0; scanning resumes from the held state when En returns to 1.
REQ-023 A change of Mode or Dir SHALL clear dcnt to 0 on that edge; idx is kept.
REQ-024 With DWELL=1, idx SHALL step on every enabled scan cycle.
REQ-025 With N=1, the block SHALL behave as a 1-to-2 decoder and scanner; Wrap pulses on every step.

Reset
REQ-026 Reset=1 SHALL immediately force idx=0, dcnt=0, en_q=0 and Wrap=0, so that y is all zeros and Idx=0, regardless of Clock.
REQ-027 Reset asserted during a scan SHALL abort it; after release, scanning restarts at index 0 with a full dwell period.
REQ-028 The first edge after reset release SHALL be treated as a normal cycle, with all inputs honoured.

Structure
REQ-029 A shared package SHALL hold the mode encodings (MODE_DIRECT=0, MODE_SCAN=1), the direction encodings (DIR_UP=0, DIR_DOWN=1) and a function giving NUM_OUT = 2**N.
REQ-030 One sub-module, onehot_dec, SHALL be used: a combinational N-to-2**N decoder with an enable input, instantiated once to drive y from idx and en_q.
REQ-031 The dcnt width SHALL be the minimum needed for DWELL-1, but at least 1 bit.

Verification
REQ-032 N=4, DWELL=3: reset, then En=1, Mode=0, Load=1, w=9 for one cycle -> from the next cycle y[9]=1 with all other bits 0, Idx=9, Wrap=0, holding steady.
REQ-033 N=4, DWELL=3, Mode=1, Dir=0, Load idx=14 -> y[14] for 3 cycles, then y[15] for 3 cycles, then y[0] with Wrap=1 in the first y[0] cycle only.
REQ-034 Same setup with Dir=1 from idx=1 -> y[1] for 3 cycles, y[0] for 3 cycles, then y[15] with a single Wrap pulse.
REQ-035 Scan running at idx=5 with dcnt=1; drop En for 4 cycles -> y=0 from the next cycle and Idx stays 5; on restoring En, y[5] holds 2 more cycles, then the scan moves to 6.
REQ-036 Assert Load with w=3 in the same cycle a step 7->8 is due -> Idx=3 with no Wrap pulse, and a full 3-cycle dwell on y[3].
REQ-037 Assert Reset asynchronously mid-dwell at idx=12 -> y=0 and Idx=0 immediately, with no clock edge needed; after release with En=1 and Mode=1, y[0] appears after one edge and steps after 3 cycles.
